mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It latches the execute-stage register bus, collects the synchronous data-SRAM read response one cycle after the execute stage issued the request, and selects the write-back value (load data or ALU result). It forwards that value on a hazard-bypass bus and hands a valid/bus pair to write-back under the standard allow_in/ready_go handshake. It buffers the SRAM response across write-back stalls so that load data is never lost.

---
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the execute->MEM, MEM->WB and SRAM read-data signals
// around the memory-access stage.
//   slave  : the view used by mem_stage (consumes EX/WB/SRAM, drives MEM outputs)
//   master : the view used by the surrounding pipeline / environment
interface mem_stage_if #(
  parameter int EXREG_W  = 107,
  parameter int MEMREG_W = 70,
  parameter int BYPASS_W = 39
);
  logic                EXreg_valid;
  logic [EXREG_W-1:0]  EXreg_bus;
  logic                EX_ready_go;
  logic                WB_allow_in;
  logic [31:0]         data_sram_rdata;
  logic                MEM_allow_in;
  logic                MEM_ready_go;
  logic [BYPASS_W-1:0] MEM_bypass_bus;
  logic                MEMreg_valid;
  logic [MEMREG_W-1:0] MEMreg_bus;

  modport slave (
    input  EXreg_valid, EXreg_bus, EX_ready_go, WB_allow_in, data_sram_rdata,
    output MEM_allow_in, MEM_ready_go, MEM_bypass_bus, MEMreg_valid, MEMreg_bus
  );

  modport master (
    output EXreg_valid, EXreg_bus, EX_ready_go, WB_allow_in, data_sram_rdata,
    input  MEM_allow_in, MEM_ready_go, MEM_bypass_bus, MEMreg_valid, MEMreg_bus
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Latches the execute payload, picks up the synchronous SRAM read data one
// cycle after the request, selects load data or ALU result for write-back,
// and publishes it on a forwarding bus.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low clear of all state
//   mif    - mem_stage_if.slave: EXreg_valid/EXreg_bus/EX_ready_go in,
//            WB_allow_in in, data_sram_rdata in; MEM_allow_in, MEM_ready_go,
//            MEM_bypass_bus, MEMreg_valid, MEMreg_bus out
//
// Build option MEM_RDATA_HOLD_EN: when defined, the SRAM response is buffered
// if write-back stalls in the response cycle, so load data survives any stall
// length. When undefined, load data is taken straight from the SRAM port and
// write-back must not stall while a load sits in this stage.
module mem_stage #(
  parameter int EXREG_W  = 107,
  parameter int MEMREG_W = 70,
  parameter int BYPASS_W = 39
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave mif
);

  // Execute payload layout, MSB first.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic [3:0]  mem_we;
    logic        rf_we;
    logic        res_from_mem;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } ex_reg_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
  } mem_reg_t;

  typedef struct packed {
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic        res_from_mem;
    logic [31:0] result;
  } bypass_t;

  logic        valid_r;
  ex_reg_t     bus_r;
  logic        ready_go;
  logic        allow_in;
  logic        take;
  logic [31:0] rdata_eff;
  logic [31:0] rf_wdata;
  mem_reg_t    mem_out;
  bypass_t     byp_out;

  assign ready_go = 1'b1;
  assign allow_in = ~valid_r | (ready_go & mif.WB_allow_in);
  // A real instruction is loaded only when execute offers one and we can take it.
  assign take     = allow_in & mif.EXreg_valid & mif.EX_ready_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      bus_r   <= '0;
    end else if (allow_in) begin
      valid_r <= mif.EXreg_valid & mif.EX_ready_go;
      // A bubble leaves the old payload in place.
      if (take) bus_r <= ex_reg_t'(mif.EXreg_bus);
    end
  end

`ifdef MEM_RDATA_HOLD_EN
  logic        first_r;
  logic        hold_vld;
  logic [31:0] hold_data;

  // The SRAM presents the response only in the first cycle an instruction
  // sits here; if write-back stalls that cycle, park the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_r   <= 1'b0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else begin
      first_r <= take;
      if (take) begin
        hold_vld <= 1'b0;
      end else if (valid_r & mif.WB_allow_in) begin
        hold_vld <= 1'b0;
      end else if (valid_r & first_r & ~mif.WB_allow_in) begin
        hold_vld  <= 1'b1;
        hold_data <= mif.data_sram_rdata;
      end
    end
  end

  assign rdata_eff = hold_vld ? hold_data : mif.data_sram_rdata;
`else
  assign rdata_eff = mif.data_sram_rdata;
`endif

  // Full-word loads only: no byte/half selection or sign extension.
  assign rf_wdata = bus_r.res_from_mem ? rdata_eff : bus_r.alu_result;

  always_comb begin
    mem_out          = '0;
    mem_out.rf_we    = bus_r.rf_we;
    mem_out.rf_waddr = bus_r.rf_waddr;
    mem_out.rf_wdata = rf_wdata;
    mem_out.pc       = bus_r.pc;
  end

  // Forwarding write-enable is qualified by occupancy so a stale payload
  // (after a bubble or reset) never looks like a pending write.
  always_comb begin
    byp_out              = '0;
    byp_out.rf_waddr     = bus_r.rf_waddr;
    byp_out.rf_we        = bus_r.rf_we & valid_r;
    byp_out.res_from_mem = bus_r.res_from_mem;
    byp_out.result       = rf_wdata;
  end

  assign mif.MEM_ready_go   = ready_go;
  assign mif.MEM_allow_in   = allow_in;
  assign mif.MEMreg_valid   = valid_r;
  assign mif.MEMreg_bus     = mem_out;
  assign mif.MEM_bypass_bus = byp_out;

  // Store data and byte enables travel with the instruction but are consumed
  // by the SRAM request in execute, not by write-back.
  logic unused_st;
  assign unused_st = ^{bus_r.rkd_value, bus_r.mem_we};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with an instruction-level model
// and a per-cycle compare process.
module tb_mem_stage;
  localparam int EXREG_W  = 107;
  localparam int MEMREG_W = 70;
  localparam int BYPASS_W = 39;
`ifdef MEM_RDATA_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.EXREG_W(EXREG_W), .MEMREG_W(MEMREG_W), .BYPASS_W(BYPASS_W)) mif ();

  mem_stage #(.EXREG_W(EXREG_W), .MEMREG_W(MEMREG_W), .BYPASS_W(BYPASS_W)) dut (
    .clk  (clk),
    .reset(reset),
    .mif  (mif.slave)
  );

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  // Tracks which instruction occupies the stage and its decoded fields.
  logic        m_vld = 1'b0, m_first = 1'b0;
  logic [31:0] m_alu = '0, m_pc = '0;
  logic [4:0]  m_waddr = '0;
  logic        m_we = 1'b0, m_rfm = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_vld   <= 1'b0;
      m_first <= 1'b0;
    end else begin
      m_first <= 1'b0;
      if (!m_vld || mif.WB_allow_in) begin
        m_vld <= mif.EXreg_valid && mif.EX_ready_go;
        if (mif.EXreg_valid && mif.EX_ready_go) begin
          m_alu   <= mif.EXreg_bus[106:75];
          m_we    <= mif.EXreg_bus[38];
          m_rfm   <= mif.EXreg_bus[37];
          m_waddr <= mif.EXreg_bus[36:32];
          m_pc    <= mif.EXreg_bus[31:0];
          m_first <= 1'b1;
        end
      end
    end
  end

  // Load value: the SRAM word seen in the instruction's first cycle (with
  // buffering), or whatever the port shows now (without).
  logic [31:0] c_ld = '0;
  always @(negedge clk) begin
    logic [31:0] ld, wd;
    if (m_vld && m_first) c_ld = mif.data_sram_rdata;
    ld = (HOLD && !m_first) ? c_ld : mif.data_sram_rdata;
    wd = m_rfm ? ld : m_alu;
    chk("cmp_valid", 70'(mif.MEMreg_valid), 70'(m_vld));
    chk("cmp_allow", 70'(mif.MEM_allow_in), 70'(!m_vld || mif.WB_allow_in));
    chk("cmp_ready", 70'(mif.MEM_ready_go), 70'd1);
    if (m_vld) begin
      chk("cmp_bus", mif.MEMreg_bus, {m_we, m_waddr, wd, m_pc});
      chk("cmp_byp", 70'(mif.MEM_bypass_bus), 70'({m_waddr, m_we, m_rfm, wd}));
    end else begin
      chk("cmp_byp_we", 70'(mif.MEM_bypass_bus[33]), 70'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] alu, input logic [3:0] mwe, input logic rfwe,
                      input logic rfm, input logic [4:0] wa, input logic [31:0] pc);
    mif.EXreg_valid = 1'b1;
    mif.EXreg_bus   = {alu, pc ^ 32'h0BAD_0000, mwe, rfwe, rfm, wa, pc};
  endtask

  task automatic idle;
    mif.EXreg_valid = 1'b0;
    mif.EXreg_bus   = '1;
  endtask

  initial begin
    logic [31:0] e1, e2;
    mif.EX_ready_go     = 1'b1;
    mif.WB_allow_in     = 1'b1;
    mif.data_sram_rdata = '0;
    idle();
    #1 reset = 1'b0;
    step();
    step();
    chk("rst_valid", 70'(mif.MEMreg_valid), 70'd0);
    chk("rst_allow", 70'(mif.MEM_allow_in), 70'd1);
    chk("rst_byp", 70'(mif.MEM_bypass_bus), 70'd0);
    chk("rst_bus", mif.MEMreg_bus, 70'd0);
    reset = 1'b1;

    // ALU instruction
    send(32'h1234_5678, 4'h0, 1'b1, 1'b0, 5'd5, 32'h1000);
    step();
    idle();
    #2;
    chk("alu_valid", 70'(mif.MEMreg_valid), 70'd1);
    chk("alu_wdata", 70'(mif.MEMreg_bus[63:32]), 70'h1234_5678);
    chk("alu_byp", 70'(mif.MEM_bypass_bus), 70'({5'd5, 1'b1, 1'b0, 32'h1234_5678}));
    step();

    // Load, no stall
    send(32'hAAAA_5555, 4'h0, 1'b1, 1'b1, 5'd6, 32'h1004);
    step();
    mif.data_sram_rdata = 32'hDEAD_BEEF;
    idle();
    #2;
    chk("ld_wdata", 70'(mif.MEMreg_bus[63:32]), 70'hDEAD_BEEF);
    step();
    mif.data_sram_rdata = 32'hFFFF_FFFF;
    #2;
    chk("ld_gone", 70'(mif.MEMreg_valid), 70'd0);

    // Three-cycle write-back stall, then leave and accept on the same edge.
    // With buffering this is a load; without, an ALU op stands in.
    e1 = HOLD ? 32'hCAFE_F00D : 32'h1111_2222;
    e2 = HOLD ? 32'h0BAD_F00D : 32'h3333_4444;
    send(32'h1111_2222, 4'h0, 1'b1, HOLD, 5'd7, 32'h1008);
    step();
    mif.data_sram_rdata = 32'hCAFE_F00D;
    mif.WB_allow_in = 1'b0;
    idle();
    #2;
    chk("st1_allow", 70'(mif.MEM_allow_in), 70'd0);
    chk("st1_wdata", 70'(mif.MEMreg_bus[63:32]), 70'(e1));
    for (int k = 0; k < 2; k++) begin
      step();
      mif.data_sram_rdata = 32'hFFFF_FFFF - k;
      #2;
      chk("stk_allow", 70'(mif.MEM_allow_in), 70'd0);
      chk("stk_wdata", 70'(mif.MEMreg_bus[63:32]), 70'(e1));
    end
    step();
    mif.data_sram_rdata = '0;
    mif.WB_allow_in = 1'b1;
    send(32'h3333_4444, 4'h0, 1'b1, HOLD, 5'd8, 32'h100C);
    #2;
    chk("st4_pc", 70'(mif.MEMreg_bus[31:0]), 70'h1008);
    chk("st4_wdata", 70'(mif.MEMreg_bus[63:32]), 70'(e1));
    step();
    mif.data_sram_rdata = 32'h0BAD_F00D;
    mif.WB_allow_in = 1'b0;
    idle();
    #2;
    chk("swap_pc", 70'(mif.MEMreg_bus[31:0]), 70'h100C);
    chk("swap_wdata", 70'(mif.MEMreg_bus[63:32]), 70'(e2));
    step();
    mif.data_sram_rdata = 32'h0;
    mif.WB_allow_in = 1'b1;
    #2;
    chk("swap_held", 70'(mif.MEMreg_bus[63:32]), 70'(e2));
    step();
    #2;
    chk("swap_gone", 70'(mif.MEMreg_valid), 70'd0);

    // Four back-to-back ALU instructions
    send(32'h100, 4'h0, 1'b1, 1'b0, 5'd1, 32'h2000);
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) send(32'h100 * (i + 1), 4'h0, 1'b1, 1'b0, 5'(i + 1), 32'h2000 + 4 * i);
      else idle();
      #2;
      chk("b2b_valid", 70'(mif.MEMreg_valid), 70'd1);
      chk("b2b_pc", 70'(mif.MEMreg_bus[31:0]), 70'(32'h2000 + 4 * (i - 1)));
      step();
    end
    #2;
    chk("b2b_end", 70'(mif.MEMreg_valid), 70'd0);

    // Store then bubble
    send(32'h55, 4'hF, 1'b0, 1'b0, 5'd9, 32'h4000);
    step();
    idle();
    #2;
    chk("sw_valid", 70'(mif.MEMreg_valid), 70'd1);
    chk("sw_byp_we", 70'(mif.MEM_bypass_bus[33]), 70'd0);
    chk("sw_rf_we", 70'(mif.MEMreg_bus[69]), 70'd0);
    step();
    #2;
    chk("bub_valid", 70'(mif.MEMreg_valid), 70'd0);
    chk("bub_keep", 70'(mif.MEMreg_bus[31:0]), 70'h4000);

    // Reset during a stall
    send(32'h6666, 4'h0, 1'b1, HOLD, 5'd10, 32'h3000);
    step();
    mif.data_sram_rdata = 32'h1357_9BDF;
    mif.WB_allow_in = 1'b0;
    idle();
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_valid", 70'(mif.MEMreg_valid), 70'd0);
    chk("mrst_allow", 70'(mif.MEM_allow_in), 70'd1);
    chk("mrst_byp_we", 70'(mif.MEM_bypass_bus[33]), 70'd0);
    step();
    step();
    reset = 1'b1;
    mif.WB_allow_in = 1'b1;
    send(32'h77, 4'h0, 1'b1, 1'b0, 5'd11, 32'h3004);
    step();
    send(32'h88, 4'h0, 1'b1, 1'b1, 5'd12, 32'h3008);
    #2;
    chk("post_wdata", 70'(mif.MEMreg_bus[63:32]), 70'h77);
    chk("post_pc", 70'(mif.MEMreg_bus[31:0]), 70'h3004);
    step();
    mif.data_sram_rdata = 32'h5A5A_5A5A;
    idle();
    #2;
    chk("post_ld", 70'(mif.MEMreg_bus[63:32]), 70'h5A5A_5A5A);
    step();
    #2;
    chk("post_gone", 70'(mif.MEMreg_valid), 70'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
